td_core_param: RTL and testbench
================================

// Module: td_core_param
// PURPOSE
//  Parametrised, multi-cycle successor of the 4-bit TD4-style operation set: a full CPU core
//  with A/B registers, carry flag, IP and OUT latch, generalised to DW-bit data / AW-bit IP.
//  Fetches from external instruction memory over a req/valid handshake, executes in a FETCH/EXEC FSM.
//  Sits between instruction ROM/RAM and board I/O (switches in, LEDs out).
// PARAMETERS
//  DW  4  data width: A, B, OUT, immediate, switch input (>=2)
//  AW  4  IP / instruction-address width (>=2); jump target = imm[AW-1:0] if AW<=DW, else zero-extended
// PORTS
//  clk         in   1        clock, all state on rising edge
//  rst         in   1        synchronous reset, active-high
//  run         in   1        1 = core may fetch; 0 = hold in FETCH, no request issued
//  imem_req    out  1        fetch request; = (state==FETCH) & run & ~halted
//  imem_addr   out  AW       fetch address; always equals ip
//  imem_valid  in   1        imem_data valid this cycle; ignored unless imem_req=1
//  imem_data   in   DW+4     instruction: [DW+3:DW] opcode, [DW-1:0] imm
//  sw_in       in   DW       switch input for IN A / IN B
//  out         out  DW       output latch
//  cf          out  1        carry flag
//  ip          out  AW       instruction pointer
//  instr_done  out  1        one-cycle pulse, registered, the cycle after EXEC
//  halted      out  1        core stopped (HLT); constant 0 without macro
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=FETCH; a, b, out, ip, cf, ir, instr_done, halted = 0. A valid
//    in the reset cycle is dropped; an outstanding fetch is abandoned (memory must tolerate drop).
//  - FETCH: imem_req high while run; on imem_valid&imem_req -> latch ir, go EXEC. run=0 -> stay,
//    req low. Min 2 cycles/instr (valid same cycle as req); wait states extend FETCH unbounded.
//  - EXEC (1 cycle): apply opcode, ip += 1 mod 2^AW unless jumping, -> FETCH. run ignored in EXEC.
//  - Opcodes: 0000 ADD A,imm; 0001 MOV A,B; 0010 IN A; 0011 MOV A,imm; 0100 MOV B,A;
//    0101 ADD B,imm; 0110 IN B; 0111 MOV B,imm; 1001 OUT B; 1011 OUT imm; 1110 JNC imm;
//    1111 JMP imm; all others NOP (1100 see CONFIGURATION).
//  - ADD: {cf,reg} = reg + imm, DW+1-bit result; carry out of bit DW-1 -> cf. Every other opcode
//    (incl. NOP, JMP, JNC) clears cf.
//  - JNC: taken iff cf==0 at EXEC (cf of previous instruction); not taken -> ip+1. cf then 0.
//  - IP wrap: ip=2^AW-1 non-jump -> 0, cf unaffected by wrap.
//  - sw_in sampled in the EXEC cycle only; no synchroniser inside (board top owns it).
//  - out changes only on OUT B / OUT imm, holds otherwise.
// CONFIGURATION
//  TD_CORE_HALT_EN defined: opcode 1100 = HLT: EXEC sets halted=1, ip not incremented, cf cleared;
//   FSM parks in FETCH with imem_req=0 until rst. run has no effect while halted.
//  Not defined: 1100 is NOP (ip+1, cf=0); halted tied 0; no extra state.
// TESTING (DW=4, AW=4, 1-cycle-latency memory unless noted)
//  Reset: rst 2 cycles mid-fetch -> ip=0, a=b=out=0, cf=0, imem_req=run next cycle, addr=0.
//  MOV A,0xF; ADD A,1; JNC 8 -> a=0, cf=1 after ADD, JNC not taken, ip=3, cf=0.
//  MOV A,0xE; ADD A,1; JNC 8 -> a=0xF, cf=0, ip=8; each instr_done 1 cycle, 2 cycles/instr.
//  sw_in=0x5: IN B; OUT B; OUT 0xA -> out=0x5 then 0xA; run=0 for 3 cycles mid-program
//   -> imem_req low, no state change; resumes same ip.
//  Wait states: imem_valid delayed 3 cycles -> ir latched once, imem_addr stable, JMP 0xF
//   then NOP -> ip 0xF -> 0x0 wrap.
//  TD_CORE_HALT_EN: HLT at ip=2 -> halted=1, ip=2, imem_req=0 for 20 cycles; rst -> halted=0.
//   Without macro same code -> ip=3, halted=0.

Source files
------------

// File: rtl/td_core_param.sv
// td_core_param: parametrised TD4-style CPU core, FETCH/EXEC FSM over an imem req/valid handshake
// Optional macro TD_CORE_HALT_EN turns opcode 1100 into HLT; otherwise 1100 is a NOP
module td_core_param #(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_valid,
    input  logic [DW+3:0] imem_data,
    input  logic [DW-1:0] sw_in,
    output logic [DW-1:0] out,
    output logic          cf,
    output logic [AW-1:0] ip,
    output logic          instr_done,
    output logic          halted
);
    localparam int XW = (AW > DW) ? AW : DW;
    typedef enum logic {FETCH, EXEC} state_t;
    state_t state, state_n;
    logic [DW+3:0] ir;
    logic [DW-1:0] a, b, imm;
    logic [3:0] op;
    logic [XW-1:0] imm_x;
    logic [AW-1:0] tgt;
    logic exec, hit, hlt;

    assign op = ir[DW+3:DW];
    assign imm = ir[DW-1:0];
    // jump target truncates imm when AW<=DW, zero-extends it otherwise
    assign imm_x = XW'(imm);
    assign tgt = imm_x[AW-1:0];
    assign exec = state == EXEC;
    assign imem_req = (state == FETCH) && run && !halted;
    assign imem_addr = ip;
    assign hit = imem_req && imem_valid;

`ifdef TD_CORE_HALT_EN
    assign hlt = op == 4'b1100;
    always_ff @(posedge clk) begin
        if (rst) halted <= 1'b0;
        else if (exec && hlt) halted <= 1'b1;
    end
`else
    assign hlt = 1'b0;
    assign halted = 1'b0;
`endif

    always_comb begin
        state_n = exec ? FETCH : (hit ? EXEC : FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
            a <= '0;
            b <= '0;
            out <= '0;
            ip <= '0;
            cf <= 1'b0;
            ir <= '0;
            instr_done <= 1'b0;
        end else begin
            state <= state_n;
            instr_done <= exec;
            if (hit) ir <= imem_data;
            if (exec) begin
                cf <= 1'b0;
                ip <= hlt ? ip : ip + AW'(1);
                case (op)
                    4'b0000: {cf, a} <= {1'b0, a} + {1'b0, imm};
                    4'b0001: a <= b;
                    4'b0010: a <= sw_in;
                    4'b0011: a <= imm;
                    4'b0100: b <= a;
                    4'b0101: {cf, b} <= {1'b0, b} + {1'b0, imm};
                    4'b0110: b <= sw_in;
                    4'b0111: b <= imm;
                    4'b1001: out <= b;
                    4'b1011: out <= imm;
                    4'b1110: if (!cf) ip <= tgt;
                    4'b1111: ip <= tgt;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_td_core_param.sv
// tb_td_core_param: directed programs against an ISA-level model of td_core_param (DW=4, AW=4)
module tb_td_core_param;
    logic clk = 0, rst, run, imem_valid = 0;
    logic [7:0] imem_data = 0;
    logic [3:0] sw_in, imem_addr, out, ip;
    logic imem_req, cf, instr_done, halted;
    int checks = 0, errors = 0, lat = 0, wcnt = 0, cyc = 0, last_done = 0, gap = 0;
    int ma, mb, mout, mcf, mip, mhalted;
    logic rst_q = 1, done_q = 0;
    logic [7:0] mem [16];

    td_core_param #(.DW(4), .AW(4)) dut (
        .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_data(imem_data), .sw_in(sw_in), .out(out),
        .cf(cf), .ip(ip), .instr_done(instr_done), .halted(halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) begin
        rst_q <= rst;
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ISA-level reference: executes the instruction at the model's own ip
    task automatic step();
        int op, im, s, nip, ncf;
        op = int'(mem[mip][7:4]);
        im = int'(mem[mip][3:0]);
        nip = (mip + 1) % 16;
        ncf = 0;
        case (op)
            0: begin s = ma + im; ma = s % 16; ncf = s / 16; end
            1: ma = mb;
            2: ma = int'(sw_in);
            3: ma = im;
            4: mb = ma;
            5: begin s = mb + im; mb = s % 16; ncf = s / 16; end
            6: mb = int'(sw_in);
            7: mb = im;
            9: mout = mb;
            11: mout = im;
            12: begin
`ifdef TD_CORE_HALT_EN
                mhalted = 1;
                nip = mip;
`endif
            end
            14: if (mcf == 0) nip = im;
            15: nip = im;
            default: ;
        endcase
        mip = nip;
        mcf = ncf;
    endtask

    // memory: answers after lat waiting cycles; non-valid data is deliberately junk
    always @(negedge clk) begin
        if (imem_req) begin
            imem_valid = wcnt >= lat;
            wcnt = (wcnt >= lat) ? 0 : wcnt + 1;
            imem_data = imem_valid ? mem[imem_addr] : 8'h7A;
        end else begin
            imem_valid = 0;
            wcnt = 0;
            imem_data = 8'h7A;
        end
    end

    always @(negedge clk) begin
        if (rst_q) begin
            ma = 0; mb = 0; mout = 0; mcf = 0; mip = 0; mhalted = 0;
        end else if (instr_done) step();
        chk("ip", int'(ip), mip);
        chk("addr", int'(imem_addr), mip);
        chk("out", int'(out), mout);
        chk("cf", int'(cf), mcf);
        chk("halted", int'(halted), mhalted);
        if (!rst_q) begin
            if (instr_done) begin
                chk("done_width", int'(done_q), 0);
                chk("req_after_done", int'(imem_req), int'(run && mhalted == 0));
            end else if (!run || mhalted != 0) chk("req_idle", int'(imem_req), 0);
        end
        done_q = instr_done;
    end

    task automatic clear();
        for (int i = 0; i < 16; i++) mem[i] = 8'h80;
    endtask

    task automatic do_reset();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic wait_done(input int n);
        int got = 0;
        for (int k = 0; k < 200 && got < n; k++) begin
            @(posedge clk);
            #1;
            if (instr_done) begin
                got++;
                gap = cyc - last_done;
                last_done = cyc;
            end
        end
        chk("done_timeout", got, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1; run = 0; sw_in = 4'h5;
        clear();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("init_ip", int'(ip), 0);
        chk("init_out", int'(out), 0);
        chk("init_req", int'(imem_req), 0);
        chk("init_done", int'(instr_done), 0);
        // reset in the middle of a wait-stated fetch
        mem[0] = 8'h77; mem[1] = 8'h90; mem[2] = 8'h35; mem[3] = 8'hF0;
        run = 1;
        wait_done(2);
        chk("p1_out", int'(out), 7);
        lat = 3;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("rst_req", int'(imem_req), 1);
        chk("rst_addr", int'(imem_addr), 0);
        chk("rst_out", int'(out), 0);
        chk("rst_cf", int'(cf), 0);
        run = 0; lat = 0;
        clear(); mem[0] = 8'h90; mem[1] = 8'hF1;
        run = 1;
        wait_done(1);
        chk("rst_b_zero", int'(out), 0);
        // carry set, JNC not taken
        run = 0; do_reset(); clear();
        mem[0] = 8'h3F; mem[1] = 8'h01; mem[2] = 8'hE8; mem[3] = 8'h40; mem[4] = 8'h90;
        run = 1;
        wait_done(2);
        chk("add_cf", int'(cf), 1);
        wait_done(1);
        chk("jnc_nt_ip", int'(ip), 3);
        chk("jnc_nt_cf", int'(cf), 0);
        // no carry, JNC taken, 2 cycles per instruction
        run = 0; do_reset(); clear();
        mem[0] = 8'h3E; mem[1] = 8'h01; mem[2] = 8'hE8; mem[8] = 8'h40; mem[9] = 8'h90;
        run = 1;
        wait_done(2);
        chk("gap_add", gap, 2);
        chk("add_nc", int'(cf), 0);
        wait_done(1);
        chk("jnc_t_ip", int'(ip), 8);
        chk("gap_jnc", gap, 2);
        wait_done(2);
        chk("a_f_out", int'(out), 15);
        // IN/OUT and a run=0 pause
        run = 0; do_reset(); clear();
        mem[0] = 8'h60; mem[1] = 8'h90; mem[2] = 8'hBA; mem[3] = 8'hF3;
        run = 1;
        wait_done(2);
        chk("in_out", int'(out), 5);
        run = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("pause_req", int'(imem_req), 0);
            chk("pause_ip", int'(ip), 2);
        end
        run = 1;
        wait_done(1);
        chk("out_imm", int'(out), 10);
        chk("resume_ip", int'(ip), 3);
        // wait states and ip wrap
        run = 0; do_reset(); clear(); lat = 3;
        mem[0] = 8'hFF; mem[15] = 8'h80;
        run = 1;
        wait_done(1);
        chk("jmp_f", int'(ip), 15);
        wait_done(1);
        chk("gap_wait", gap, 5);
        chk("wrap_ip", int'(ip), 0);
        lat = 0;
        // HLT (or NOP without the macro)
        run = 0; do_reset(); clear();
        mem[0] = 8'h3F; mem[1] = 8'h01; mem[2] = 8'hC0; mem[3] = 8'hB9; mem[4] = 8'hF4;
        run = 1;
        wait_done(3);
        chk("hlt_cf", int'(cf), 0);
`ifdef TD_CORE_HALT_EN
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("hlt_halted", int'(halted), 1);
            chk("hlt_ip", int'(ip), 2);
            chk("hlt_req", int'(imem_req), 0);
        end
        do_reset();
        chk("hlt_rst", int'(halted), 0);
`else
        chk("nop_ip", int'(ip), 3);
        chk("nop_halted", int'(halted), 0);
        wait_done(1);
        chk("nop_out", int'(out), 9);
`endif
        run = 0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
